// File: rtl/adder_entry_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// adder_entry_sequencer_pkg
// Shared types and constants for the adder entry sequencer:
//   state_e        - entry sequence states, GET_A .. SHOW
//   sum_t          - registered sum width (0..10 fits in 5 bits)
//   DIGIT_TEN      - threshold used to split the sum into tens/ones
//   state_to_led() - one-hot LED pattern for a state (bit 0 = GET_A)
// -----------------------------------------------------------------------------
package adder_entry_sequencer_pkg;

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_C   = 3'd2,
        GET_CIN = 3'd3,
        ADD     = 3'd4,
        SHOW    = 3'd5
    } state_e;

    typedef logic [4:0] sum_t;

    localparam sum_t DIGIT_TEN = 5'd10;

    // Enum values are consecutive from 0, so the LED bit index is the
    // state encoding itself.
    function automatic logic [5:0] state_to_led(input state_e s);
        return 6'b000001 << s;
    endfunction

endpackage

// File: rtl/adder_entry_sequencer_if.sv
// -----------------------------------------------------------------------------
// adder_entry_sequencer_if
// Board-side signal bundle of the adder entry sequencer.
//   sw[2:0]      - operand value (sw[1:0]) and carry-in value (sw[2])
//   key_enter_n  - active-low "accept / advance" pushbutton
//   key_clear_n  - active-low "abort / restart" pushbutton
//   HEX1, HEX0   - active-low seven-segment digits, [0:6] = a..g
//   ledr         - one-hot state indicator
//   sum_valid    - high while the result is displayed
// master drives switches/keys (board or bench), slave is the sequencer.
// -----------------------------------------------------------------------------
interface adder_entry_sequencer_if;

    logic [2:0] sw;
    logic       key_enter_n;
    logic       key_clear_n;
    logic [0:6] HEX1;
    logic [0:6] HEX0;
    logic [5:0] ledr;
    logic       sum_valid;

    modport master (
        output sw, key_enter_n, key_clear_n,
        input  HEX1, HEX0, ledr, sum_valid
    );

    modport slave (
        input  sw, key_enter_n, key_clear_n,
        output HEX1, HEX0, ledr, sum_valid
    );

endinterface

// File: rtl/adder_entry_sequencer_key_edge_detect.sv
// -----------------------------------------------------------------------------
// key_edge_detect
// Synchronises an active-low pushbutton and emits a one-cycle pulse on each
// press (synchronised falling edge). Holding the key yields a single pulse.
//   clk, rst_n - clock, asynchronous active-low reset
//   key_n_i    - raw active-low key
//   pulse_o    - one-cycle press pulse, SYNC_STAGES cycles after key_n_i falls
// -----------------------------------------------------------------------------
module key_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] settle_q;
    logic                   prev_q;
    logic                   settled;

    // The synchroniser resets to "released", which would fake a release
    // followed by a press for a key held through reset. settle_q blocks edge
    // detection until the chain holds real samples, and prev_q starts as
    // "pressed" so a held key must be seen released before it can fire.
    assign settled = settle_q[SYNC_STAGES-1];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '1;
            settle_q <= '0;
            prev_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], key_n_i};
            settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
            prev_q   <= settled ? sync_q[SYNC_STAGES-1] : 1'b0;
        end
    end

    assign pulse_o = settled & prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sevensegment.sv
// -----------------------------------------------------------------------------
// sevensegment
// Decimal digit to seven-segment decoder, active-low outputs.
//   value_i - digit value, 0..9 decoded, anything larger blanks the digit
//   seg_o   - segments [0:6] = a..g, 0 = lit
// -----------------------------------------------------------------------------
module sevensegment #(
    parameter int W = 5
) (
    input  logic [W-1:0] value_i,
    output logic [0:6]   seg_o
);

    // NOTE: every combinational output gets a default first so that no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        seg_o = 7'b1111111;
        case (value_i)
            W'(0): seg_o = 7'b0000001;
            W'(1): seg_o = 7'b1001111;
            W'(2): seg_o = 7'b0010010;
            W'(3): seg_o = 7'b0000110;
            W'(4): seg_o = 7'b1001100;
            W'(5): seg_o = 7'b0100100;
            W'(6): seg_o = 7'b0100000;
            W'(7): seg_o = 7'b0001111;
            W'(8): seg_o = 7'b0000000;
            W'(9): seg_o = 7'b0000100;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/adder_entry_sequencer.sv
// -----------------------------------------------------------------------------
// adder_entry_sequencer
// Clocked entry front-end for the 3-operand 2-bit adder. The user enters A, B,
// C (sw[1:0]) and carry-in (sw[2]) with one enter press per step; the sum
// (0..10) is registered and shown on two seven-segment digits.
//   clock   - system clock
//   resetn  - asynchronous active-low reset
//   bus     - slave side of adder_entry_sequencer_if (switches, keys,
//             HEX1/HEX0 digits, one-hot ledr, sum_valid)
// -----------------------------------------------------------------------------
module adder_entry_sequencer
    import adder_entry_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DIGIT_W     = 5
) (
    input  logic                        clock,
    input  logic                        resetn,
    adder_entry_sequencer_if.slave      bus
);

    logic               enter_pulse;
    logic               clear_pulse;
    logic [2:0]         sw_sync_q [SYNC_STAGES];
    logic [2:0]         sw_s;

    state_e             state_q;
    logic [1:0]         a_q, b_q, c_q;
    logic               cin_q;
    sum_t               sum_q;
    logic [DIGIT_W-1:0] tens_q;
    logic [DIGIT_W-1:0] ones_q;

    key_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_enter (
        .clk     (clock),
        .rst_n   (resetn),
        .key_n_i (bus.key_enter_n),
        .pulse_o (enter_pulse)
    );

    key_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_clear (
        .clk     (clock),
        .rst_n   (resetn),
        .key_n_i (bus.key_clear_n),
        .pulse_o (clear_pulse)
    );

    // Switch synchroniser; same depth as the keys so a switch set together
    // with a key press is already stable when the enter pulse arrives.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= 3'b000;
        end else begin
            sw_sync_q[0] <= bus.sw;
            for (int i = 1; i < SYNC_STAGES; i++) sw_sync_q[i] <= sw_sync_q[i-1];
        end
    end

    assign sw_s = sw_sync_q[SYNC_STAGES-1];

    // Sequencer and display registers. The digit registers follow the current
    // state, so the segments lag a state or switch change by one cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= GET_A;
            a_q     <= 2'b00;
            b_q     <= 2'b00;
            c_q     <= 2'b00;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            tens_q  <= DIGIT_W'(1);
            ones_q  <= '0;
        end else begin
            case (state_q)
                GET_A:   begin tens_q <= DIGIT_W'(1); ones_q <= DIGIT_W'(sw_s[1:0]); end
                GET_B:   begin tens_q <= DIGIT_W'(2); ones_q <= DIGIT_W'(sw_s[1:0]); end
                GET_C:   begin tens_q <= DIGIT_W'(3); ones_q <= DIGIT_W'(sw_s[1:0]); end
                GET_CIN: begin tens_q <= DIGIT_W'(4); ones_q <= DIGIT_W'(sw_s[2]);   end
                SHOW: begin
                    // Sum never exceeds 10, so a single compare replaces a divider.
                    if (sum_q >= DIGIT_TEN) begin
                        tens_q <= DIGIT_W'(1);
                        ones_q <= DIGIT_W'(sum_q - DIGIT_TEN);
                    end else begin
                        tens_q <= '0;
                        ones_q <= DIGIT_W'(sum_q);
                    end
                end
                default: ; // ADD holds the previous frame
            endcase

            if (clear_pulse) begin
                state_q <= GET_A;
                a_q     <= 2'b00;
                b_q     <= 2'b00;
                c_q     <= 2'b00;
                cin_q   <= 1'b0;
                sum_q   <= '0;
            end else begin
                case (state_q)
                    GET_A:   if (enter_pulse) begin a_q   <= sw_s[1:0]; state_q <= GET_B;   end
                    GET_B:   if (enter_pulse) begin b_q   <= sw_s[1:0]; state_q <= GET_C;   end
                    GET_C:   if (enter_pulse) begin c_q   <= sw_s[1:0]; state_q <= GET_CIN; end
                    GET_CIN: if (enter_pulse) begin cin_q <= sw_s[2];   state_q <= ADD;     end
                    ADD: begin
                        sum_q   <= sum_t'(a_q) + sum_t'(b_q) + sum_t'(c_q) + sum_t'(cin_q);
                        state_q <= SHOW;
                    end
                    SHOW:    if (enter_pulse) state_q <= GET_A;
                    default: state_q <= GET_A;
                endcase
            end
        end
    end

    assign bus.ledr      = state_to_led(state_q);
    assign bus.sum_valid = (state_q == SHOW);

    sevensegment #(.W(DIGIT_W)) u_hex1 (.value_i(tens_q), .seg_o(bus.HEX1));
    sevensegment #(.W(DIGIT_W)) u_hex0 (.value_i(ones_q), .seg_o(bus.HEX0));

endmodule

// File: doc/adder_entry_sequencer.md
Name: adder_entry_sequencer

Overview:
Sequential front-end controller for the 3-operand 2-bit adder datapath on the lab board. It walks the user through entering operands A, B, C and carry-in from switches, one pushbutton press per step. It then computes the registered sum (0..10) and drives the two seven-segment digits through the existing sevensegment decoder. It replaces the free-running combinational hookup with a clocked, debounce-safe entry sequence.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the key/switch synchronisers (min 2)
DIGIT_W, 5, width of the value fed to each sevensegment instance

Ports:
clock  input  1  system clock (50 MHz board clock)
resetn  input  1  asynchronous active-low reset
sw  input  3  sw[1:0] = 2-bit operand value; sw[2] = carry-in value (used only in GET_CIN)
key_enter_n  input  1  active-low pushbutton: accept current entry / advance
key_clear_n  input  1  active-low pushbutton: abort and restart at GET_A
HEX1  output  [0:6]  tens digit / step index, active-low segments a..g
HEX0  output  [0:6]  ones digit / live operand, active-low segments a..g
ledr  output  6  one-hot state indicator, bit order GET_A..SHOW
sum_valid  output  1  high while result is displayed

Behaviour:
- Reset (resetn low, async): state=GET_A; A=B=C=0, cin=0, sum=0; sum_valid=0; ledr=6'b000001; HEX1 shows 1 (7'b1001111), HEX0 shows live sw[1:0]. Synchronisers clear to "not pressed" (1).
- Inputs: keys and sw pass SYNC_STAGES flops; enter_pulse/clear_pulse = one-cycle pulse on synchronised falling edge (press). Holding a key produces exactly one pulse.
- Press latency: state changes on the clock edge after the pulse, i.e. SYNC_STAGES+1 cycles after the raw key falls.
- States and transitions (clear_pulse has priority over enter_pulse in every state):
  GET_A: enter -> latch A=sw[1:0], go GET_B.
  GET_B: enter -> latch B, go GET_C.
  GET_C: enter -> latch C, go GET_CIN.
  GET_CIN: enter -> latch cin=sw[2], go ADD.
  ADD: exactly one cycle, ignores keys except clear; sum <= A+B+C+cin (5-bit, zero-extended, max 10, no overflow possible); go SHOW.
  SHOW: sum_valid=1; enter -> go GET_A (A,B,C,cin retained until overwritten); clear -> GET_A.
  Any state, clear_pulse -> GET_A, A=B=C=cin=0, sum=0, sum_valid=0.
- Display:
  GET_A..GET_C: HEX1 = step 1/2/3; HEX0 = live synchronised sw[1:0].
  GET_CIN: HEX1 = 4, HEX0 = sw[2].
  ADD: display holds previous frame.
  SHOW: HEX1 = sum/10 (0 or 1), HEX0 = sum%10. Split via compare (sum>=10), no divider.
- Display values are registered; segments follow one cycle after the state/value change.
- Encoding ([0:6]=a..g, active-low) comes from sevensegment for 0..9; values >9 never reach the decoders.
- Reset asserted mid-sequence discards partial entries; no pulse is generated by a key held through reset release.

Decomposition:
- Shared package: state enum (GET_A, GET_B, GET_C, GET_CIN, ADD, SHOW), one-hot LED mapping, DIGIT_TEN constant (5'd10).
- One natural sub-module: key_edge_detect (synchroniser + falling-edge pulse), instantiated twice.
- Reuse the existing sevensegment decoder twice for the digits.

Test Plan:
- Reset with keys released -> ledr=000001, HEX1=7'b1001111, sum_valid=0; set sw=2'b10 -> HEX0 shows 2 (7'b0010010) within SYNC_STAGES+1 cycles.
- Enter A=3, B=3, C=3, cin=1 -> ADD for 1 cycle, then SHOW with sum=10, HEX1=1 (7'b1001111), HEX0=0 (7'b0000001), sum_valid=1.
- Enter A=1, B=2, C=0, cin=0 -> sum=3, HEX1=0, HEX0=3 (7'b0000110); enter in SHOW -> GET_A, sum_valid=0.
- Hold key_enter_n low 100 cycles in GET_A -> exactly one advance (state GET_B), not GET_C.
- In GET_C press enter and clear in the same cycle -> state GET_A, A=B=C=0; also assert resetn low mid-GET_B -> immediate GET_A, ledr=000001.
